apb_master_arbiter: RTL and testbench

- Shares the bridge's single APB master port between NUM_REQ requesters (AHB-side bridge front end, DMA, config engine).
- Arbitrates round-robin, sequences the IDLE/SETUP/ACCESS protocol itself, and returns read data or error to the winning requester.
- Bounds slave wait states with a timeout counter.
- Sits between the bridge request layer and the APB slave bus.

---
 rtl/apb_bridge_pkg.sv | 14 +
 rtl/apb_master_arbiter_if.sv | 26 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/apb_master_arbiter.sv | 158 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and default widths for the APB bridge master-side blocks.
package apb_bridge_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus between the arbitrated master port and the slave fabric.
interface apb_master_arbiter_if #(
    parameter int ADDR_W = apb_bridge_pkg::DEF_ADDR_W,
    parameter int DATA_W = apb_bridge_pkg::DEF_DATA_W
);

    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr_i, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_req_o
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last pass revisits ptr itself.
    always_comb begin
        gnt_idx_o = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found_s && req_i[cand_s]) begin
                found_s   = 1'b1;
                gnt_idx_o = cand_s;
            end else begin
                found_s   = found_s;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters,
// with full SETUP/ACCESS sequencing and a wait-state timeout.
module apb_master_arbiter
    import apb_bridge_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16,
    localparam int IDX_W  = $clog2(NUM_REQ),
    localparam int CNT_W  = $clog2(TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_done_o,
    output logic                      req_err_o,
    output logic [DATA_W-1:0]         req_rdata_o,
    output logic [IDX_W-1:0]          gnt_idx_o,
    apb_master_arbiter_if.master      apb
);

    logic [ADDR_W-1:0] addr_arr_s  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr_s [NUM_REQ];
    logic [IDX_W-1:0]  win_idx_s;
    logic              any_req_s;
    logic              finish_s;

    apb_state_t        state_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  gnt_idx_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic [NUM_REQ-1:0] done_r;
    logic              err_r;
    logic [DATA_W-1:0] rdata_r;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr_s[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
        assign wdata_arr_s[k] = req_wdata_i[k*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_r),
        .gnt_idx_o (win_idx_s),
        .any_req_o (any_req_s)
    );

    // ACCESS ends on a ready slave or on the last allowed wait state.
    assign finish_s = apb.pready_i || (cnt_r == CNT_W'(TIMEOUT - 1));

    // Transfer sequencer: arbitration, APB phases, timeout and response pulse.
    always_ff @(posedge clk) begin
        if (preset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= IDX_W'(NUM_REQ - 1);
            gnt_idx_r <= '0;
            cnt_r     <= '0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            done_r    <= '0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= '0;
                    err_r  <= 1'b0;
                    rdata_r <= '0;
                    cnt_r  <= '0;
                    if (any_req_s) begin
                        gnt_idx_r <= win_idx_s;
                        ptr_r     <= win_idx_s;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        pwrite_r  <= req_write_i[win_idx_s];
                        paddr_r   <= addr_arr_s[win_idx_s];
                        pwdata_r  <= wdata_arr_s[win_idx_s];
                        state_r   <= ST_SETUP;
                    end else begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        pwrite_r  <= 1'b0;
                        paddr_r   <= '0;
                        pwdata_r  <= '0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (finish_s) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        pwrite_r  <= 1'b0;
                        paddr_r   <= '0;
                        pwdata_r  <= '0;
                        cnt_r     <= '0;
                        done_r    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_r;
                        // Timeout counts as an error; read data only survives a clean read.
                        err_r     <= apb.pready_i ? apb.pslverr_i : 1'b1;
                        rdata_r   <= (apb.pready_i && !apb.pslverr_i && !pwrite_r) ?
                                     apb.prdata_i : '0;
                        state_r   <= ST_RESP;
                    end else begin
                        cnt_r     <= cnt_r + CNT_W'(1'b1);
                        state_r   <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    done_r  <= '0;
                    err_r   <= 1'b0;
                    rdata_r <= '0;
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    pwrite_r  <= 1'b0;
                    paddr_r   <= '0;
                    pwdata_r  <= '0;
                    done_r    <= '0;
                    err_r     <= 1'b0;
                    rdata_r   <= '0;
                    cnt_r     <= '0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign apb.psel_o    = psel_r;
    assign apb.penable_o = penable_r;
    assign apb.pwrite_o  = pwrite_r;
    assign apb.paddr_o   = paddr_r;
    assign apb.pwdata_o  = pwdata_r;
    assign req_done_o    = done_r;
    assign req_err_o     = err_r;
    assign req_rdata_o   = rdata_r;
    assign gnt_idx_o     = gnt_idx_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed, table-driven bench for apb_master_arbiter plus multi-cycle sequences.
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         preset;
    logic [3:0]   req_valid;
    logic [3:0]   req_write;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_done;
    logic         req_err;
    logic [31:0]  req_rdata;
    logic [1:0]   gnt_idx;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    assign apb.prdata_i  = prdata;
    assign apb.pready_i  = pready;
    assign apb.pslverr_i = pslverr;

    apb_master_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .preset      (preset),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_done_o  (req_done),
        .req_err_o   (req_err),
        .req_rdata_o (req_rdata),
        .gnt_idx_o   (gnt_idx),
        .apb         (apb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  write;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
        logic        e_psel;
        logic        e_pen;
        logic        e_pwr;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [3:0]  e_done;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [1:0]  e_gnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] valid, logic [3:0] write,
                                logic rdy, logic serr, logic [31:0] prd,
                                logic psel, logic pen, logic pwr, logic [31:0] paddr,
                                logic [31:0] pwdata, logic [3:0] done, logic err,
                                logic [31:0] rdata, logic [1:0] gnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.write = write; v.pready = rdy; v.pslverr = serr;
        v.prdata = prd; v.e_psel = psel; v.e_pen = pen; v.e_pwr = pwr; v.e_paddr = paddr;
        v.e_pwdata = pwdata; v.e_done = done; v.e_err = err; v.e_rdata = rdata; v.e_gnt = gnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 3, 1};

    initial begin
        int acc_cnt;
        int seen;
        int slot;
        int phase;

        preset    = 1'b1;
        req_valid = 4'b0000;
        req_write = 4'b0000;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'h0;
        req_addr  = {32'h0000_C000, 32'h0000_A004, 32'h0000_B000, 32'h0000_A000};
        req_wdata = {32'h4444_0003, 32'h1234_5678, 32'h2222_0001, 32'h1111_0000};

        // rst valid write rdy serr prdata | psel pen pwr paddr pwdata done err rdata gnt
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd0));
        vecs.push_back(mk(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd0));
        // single zero-wait read by requester 0
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b1, 1'b0, 1'b0, 32'h0000_A000, 32'h1111_0000, 4'b0000, 1'b0, 32'h0, 2'd0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h0000_A000, 32'h1111_0000, 4'b0000, 1'b0, 32'h0, 2'd0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'hDEAD_BEEF,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0001, 1'b0, 32'hDEAD_BEEF, 2'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd0));
        // write by requester 2, three wait states, inputs disturbed mid-transfer
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0,
                          1'b1, 1'b0, 1'b1, 32'h0000_A004, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b1, 32'h0000_A004, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1, 32'h0,
                          1'b1, 1'b1, 1'b1, 32'h0000_A004, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0100, 1'b0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b1, 32'h0000_A004, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0100, 1'b0, 1'b0, 32'h0,
                          1'b1, 1'b1, 1'b1, 32'h0000_A004, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0101, 4'b0100, 1'b1, 1'b0, 32'hCAFE_F00D,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100, 1'b0, 32'h0, 2'd2));
        // no arbitration in RESP, then requester 0 wins from pointer 2
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b1, 1'b0, 1'b0, 32'h0000_A000, 32'h1111_0000, 4'b0000, 1'b0, 32'h0, 2'd0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h0000_A000, 32'h1111_0000, 4'b0000, 1'b0, 32'h0, 2'd0));
        // pslverr without pready: still waiting, no completion
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 32'h0,
                          1'b1, 1'b1, 1'b0, 32'h0000_A000, 32'h1111_0000, 4'b0000, 1'b0, 32'h0, 2'd0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h5555_AAAA,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0001, 1'b1, 32'h0, 2'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd0));

        for (int r = 0; r < vecs.size(); r++) begin
            preset    = vecs[r].rst;
            req_valid = vecs[r].valid;
            req_write = vecs[r].write;
            pready    = vecs[r].pready;
            pslverr   = vecs[r].pslverr;
            prdata    = vecs[r].prdata;
            tick();
            chk($sformatf("row%0d psel", r),    64'(apb.psel_o),    64'(vecs[r].e_psel));
            chk($sformatf("row%0d penable", r), 64'(apb.penable_o), 64'(vecs[r].e_pen));
            chk($sformatf("row%0d pwrite", r),  64'(apb.pwrite_o),  64'(vecs[r].e_pwr));
            chk($sformatf("row%0d paddr", r),   64'(apb.paddr_o),   64'(vecs[r].e_paddr));
            chk($sformatf("row%0d pwdata", r),  64'(apb.pwdata_o),  64'(vecs[r].e_pwdata));
            chk($sformatf("row%0d done", r),    64'(req_done),      64'(vecs[r].e_done));
            chk($sformatf("row%0d err", r),     64'(req_err),       64'(vecs[r].e_err));
            chk($sformatf("row%0d rdata", r),   64'(req_rdata),     64'(vecs[r].e_rdata));
            chk($sformatf("row%0d gnt", r),     64'(gnt_idx),       64'(vecs[r].e_gnt));
        end

        // Round-robin with every requester held, then only 1 and 3.
        preset = 1'b1; req_valid = 4'b1111; req_write = 4'b0000; pready = 1'b1; pslverr = 1'b0;
        prdata = 32'h0000_0042;
        tick(); tick();
        preset = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            slot  = (c - 1) / 4;
            phase = (c - 1) % 4;
            if (phase == 0) begin
                chk($sformatf("rr c%0d setup", c), 64'({apb.psel_o, apb.penable_o}), 64'(2'b10));
                chk($sformatf("rr c%0d gnt", c), 64'(gnt_idx), 64'(rr_exp[slot]));
            end else if (phase == 2) begin
                chk($sformatf("rr c%0d done", c), 64'(req_done), 64'(4'b0001 << rr_exp[slot]));
            end
            if (c == 20) req_valid = 4'b1010;
        end

        // Timeout: requester 3 read against a slave that never answers.
        preset = 1'b1; req_valid = 4'b0000; pready = 1'b0;
        tick(); tick();
        preset = 1'b0; req_valid = 4'b1000; req_write = 4'b0000; prdata = 32'hFFFF_FFFF;
        acc_cnt = 0;
        seen    = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            tick();
            if (apb.psel_o && apb.penable_o) acc_cnt++;
            if (req_done != 4'b0000) seen = 1;
        end
        chk("timeout seen", 64'(seen), 64'(1));
        chk("timeout access cycles", 64'(acc_cnt), 64'(TIMEOUT));
        chk("timeout done", 64'(req_done), 64'(4'b1000));
        chk("timeout err", 64'(req_err), 64'(1'b1));
        chk("timeout rdata", 64'(req_rdata), 64'(32'h0));
        req_valid = 4'b0000;
        tick();
        chk("timeout idle bus", 64'({apb.psel_o, apb.penable_o}), 64'(2'b00));
        chk("timeout idle done", 64'(req_done), 64'(4'b0000));
        chk("timeout idle gnt", 64'(gnt_idx), 64'(2'd3));

        // Reset during ACCESS aborts silently and restarts arbitration at 0.
        req_valid = 4'b0100; req_write = 4'b0100;
        tick();
        chk("rst setup gnt", 64'(gnt_idx), 64'(2'd2));
        tick();
        chk("rst access", 64'({apb.psel_o, apb.penable_o}), 64'(2'b11));
        preset = 1'b1; pready = 1'b1;
        tick();
        chk("rst bus", 64'({apb.psel_o, apb.penable_o}), 64'(2'b00));
        chk("rst done", 64'(req_done), 64'(4'b0000));
        chk("rst gnt", 64'(gnt_idx), 64'(2'd0));
        preset = 1'b0; req_valid = 4'b1111; pready = 1'b0;
        tick();
        chk("rst regrant setup", 64'({apb.psel_o, apb.penable_o}), 64'(2'b10));
        chk("rst regrant gnt", 64'(gnt_idx), 64'(2'd0));
        chk("rst regrant done", 64'(req_done), 64'(4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
